// File: rtl/lupdate_pkg.sv
// Shared constants and beat bundle for the beacon-update filter.
// Tags, PTP match fields, beat indices and FSM encodings live here.
package lupdate_pkg;

  localparam logic [1:0] TAG_HEAD = 2'b01;
  localparam logic [1:0] TAG_MID  = 2'b11;
  localparam logic [1:0] TAG_TAIL = 2'b10;

  localparam logic [15:0] PTP_ETYPE  = 16'h88f7;
  localparam logic [3:0]  SUB_REPORT = 4'he;
  localparam logic [3:0]  SUB_UPDATE = 4'hf;

  localparam logic [3:0] BEAT_CLASS = 4'd2;
  localparam logic [3:0] BEAT_PARAM = 4'd6;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_PASS = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  typedef struct packed {
    logic         wr;
    logic         valid;
    logic         valid_wr;
    logic         drop;
    logic [133:0] data;
  } beat_t;

endpackage

// File: rtl/lupdate_delay_line.sv
// Three-stage tagged shift register; mark retro-drops the two
// beats already in flight when a packet is classified as an update.
module lupdate_delay_line
  import lupdate_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  beat_t in_beat,
  input  logic  mark,
  output beat_t out_beat
);

  beat_t st0, st1, st2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st0 <= '0;
      st1 <= '0;
      st2 <= '0;
    end else begin
      st0      <= in_beat;
      st1      <= st0;
      st1.drop <= st0.drop | mark;
      st2      <= st1;
      st2.drop <= st1.drop | mark;
    end
  end

  assign out_beat = st2;

endmodule

// File: rtl/lupdate.sv
// Beacon-update filter: swallows PTP update packets addressed to us
// and commits their parameters; all other traffic is delayed 3 cycles.
module lupdate
  import lupdate_pkg::*;
#(
  parameter logic [7:0] LMID = 8'd12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_lu_data_wr,
  input  logic [133:0] in_lu_data,
  input  logic         in_lu_data_valid,
  input  logic         in_lu_data_valid_wr,
  input  logic [47:0]  in_local_mac_id,
  output logic         out_lu_data_wr,
  output logic [133:0] out_lu_data,
  output logic         out_lu_data_valid,
  output logic         out_lu_data_valid_wr,
  output logic         direction,
  output logic [31:0]  token_bucket_para,
  output logic [47:0]  direct_mac_addr,
  output logic         beacon_update_master,
  output logic [15:0]  update_pkt_cnt,
  output logic [15:0]  update_err_cnt
);

  // module ID is carried for metadata routing only
  if (LMID == 8'd0) begin : g_no_lmid
  end

  logic [1:0]   state, state_nx;
  logic [3:0]   cnt;
  logic [47:0]  sh_mac;
  logic         sh_dir;
  logic [31:0]  sh_tb;

  logic [1:0]   tag;
  logic [127:0] pl;
  logic         is_head, is_tail, live, body;
  logic [3:0]   idx;
  logic         match, classify, hit;
  logic         upd_end, commit, err_ev, cap;
  beat_t        dl_in, dl_out;

  assign tag     = in_lu_data[133:132];
  assign pl      = in_lu_data[127:0];
  assign is_head = in_lu_data_wr & (tag == TAG_HEAD);
  assign is_tail = in_lu_data_wr & (tag == TAG_TAIL);
  assign live    = is_head | (state != ST_IDLE);
  assign body    = in_lu_data_wr & ~is_head & (state != ST_IDLE);
  assign idx     = is_head ? 4'd0 : cnt;

  assign match = (pl[127:80] == in_local_mac_id)
               & (pl[31:16] == PTP_ETYPE)
               & (pl[11:8] == SUB_UPDATE);

  assign classify = body & (state == ST_HOLD) & (idx == BEAT_CLASS);
  assign hit      = classify & match;

  assign upd_end = is_tail & ((state == ST_DROP) | hit);
  assign commit  = upd_end & (idx >= BEAT_PARAM);
  assign err_ev  = (upd_end & (idx < BEAT_PARAM))
                 | (is_head & (state == ST_DROP));
  assign cap     = body & (state == ST_DROP) & (idx == BEAT_PARAM);

  always_comb begin
    dl_in          = '0;
    dl_in.wr       = in_lu_data_wr & live;
    dl_in.data     = (in_lu_data_wr & live) ? in_lu_data : '0;
    dl_in.valid    = live & in_lu_data_valid_wr & in_lu_data_valid;
    dl_in.valid_wr = live & in_lu_data_valid_wr;
    dl_in.drop     = hit | ((state == ST_DROP) & ~is_head);
  end

  lupdate_delay_line u_dl (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_beat  (dl_in),
    .mark     (hit),
    .out_beat (dl_out)
  );

  assign out_lu_data_wr       = dl_out.wr & ~dl_out.drop;
  assign out_lu_data          = dl_out.drop ? '0 : dl_out.data;
  assign out_lu_data_valid    = dl_out.valid & ~dl_out.drop;
  assign out_lu_data_valid_wr = dl_out.valid_wr & ~dl_out.drop;

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (is_head) state_nx = ST_HOLD;
      ST_HOLD: begin
        if (is_head)       state_nx = ST_HOLD;
        else if (is_tail)  state_nx = ST_IDLE;
        else if (classify) state_nx = match ? ST_DROP : ST_PASS;
      end
      default: begin
        if (is_head)      state_nx = ST_HOLD;
        else if (is_tail) state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      if (is_head)
        cnt <= 4'd1;
      else if (body && cnt != 4'd15)
        cnt <= cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_mac <= '0;
      sh_dir <= 1'b0;
      sh_tb  <= '0;
    end else if (cap) begin
      sh_mac <= pl[127:80];
      sh_dir <= pl[79];
      sh_tb  <= pl[63:32];
    end
  end

  // a tail on beat 6 commits straight from the incoming payload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      direct_mac_addr      <= '0;
      direction            <= 1'b0;
      token_bucket_para    <= '0;
      beacon_update_master <= 1'b0;
      update_pkt_cnt       <= '0;
      update_err_cnt       <= '0;
    end else begin
      if (commit) begin
        direct_mac_addr      <= cap ? pl[127:80] : sh_mac;
        direction            <= cap ? pl[79] : sh_dir;
        token_bucket_para    <= cap ? pl[63:32] : sh_tb;
        beacon_update_master <= ~beacon_update_master;
        update_pkt_cnt       <= update_pkt_cnt + 16'd1;
      end
      if (err_ev)
        update_err_cnt <= update_err_cnt + 16'd1;
    end
  end

endmodule
